// File: rtl/instruction_memory.sv
// instruction_memory
// Word-addressed instruction store for the RV32I fetch stage.
// The read path is purely combinational: `instruction` follows `pc` with no
// clock, so IF can latch the word in the same cycle it presents the address.
//
// Build option:
//   IMEM_LOAD_EN  defined   -> register-array memory with a synchronous load
//                              port (load_en/load_addr/load_data); reset
//                              re-initialises every word to the boot image.
//   IMEM_LOAD_EN  undefined -> constant ROM holding the boot image; clk is
//                              unused and reset only forces the NOP output.
module instruction_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
`ifdef IMEM_LOAD_EN
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
`endif
  output logic        misaligned
);

  // Word-index width; the byte address splits as {range bits, index, 2'b00}.
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Boot image: a three-instruction preamble followed by NOP fill.
  function automatic logic [31:0] boot_word(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'h0010_0093; // ADDI x1,x0,1
      1:       w = 32'h0020_0113; // ADDI x2,x0,2
      2:       w = 32'h0020_81B3; // ADD  x3,x1,x2
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  logic [AW-1:0] w_rd_index;
  logic          w_rd_in_range;
  logic [31:0]   w_rd_word;

  // Because the depth is a power of two, "pc < 4*DEPTH_WORDS" reduces to
  // every bit above the word index being zero.
  assign w_rd_index    = pc[AW+1:2];
  assign w_rd_in_range = (pc[31:AW+2] == '0);

`ifdef IMEM_LOAD_EN

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [AW-1:0] w_wr_index;
  logic          w_wr_in_range;
  logic          w_unused;

  assign w_wr_index    = load_addr[AW+1:2];
  assign w_wr_in_range = (load_addr[31:AW+2] == '0);

  // Byte-offset bits of the load address select nothing.
  assign w_unused = ^load_addr[1:0];

  // Load port: one word per cycle, out-of-range writes dropped; reset
  // restores the boot image asynchronously.
  // NOTE: this array is reset because the boot image must reappear on every
  // reset; that forces flops rather than a RAM macro, which is intended here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= boot_word(i);
      end
    end else if (load_en && w_wr_in_range) begin
      r_mem[w_wr_index] <= load_data;
    end
  end

  // Combinational read of the live array (no write-to-read bypass).
  assign w_rd_word = r_mem[w_rd_index];

`else

  logic w_unused;

  // The ROM build has no sequential logic at all.
  assign w_unused = clk;

  // Combinational ROM lookup of the boot image.
  // NOTE: every path assigns w_rd_word, so no latch is inferred.
  always_comb begin
    w_rd_word = boot_word(32'(w_rd_index));
  end

`endif

  // Output mux: NOP while in reset or beyond the end of the store.
  always_comb begin
    instruction = NOP_WORD;
    if (rst_n && w_rd_in_range) begin
      instruction = w_rd_word;
    end
  end

  // Alignment flag is independent of reset and range.
  assign misaligned = |pc[1:0];

endmodule

// File: tb/tb_instruction_memory.sv
// Testbench for instruction_memory (default depth 256).
// Driver issues directed pc/reset/load vectors and queues the expected
// read-port response; a separate monitor samples the DUT and compares.
// Load-port scenarios are compiled only when IMEM_LOAD_EN is defined.
module tb_instruction_memory;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] W0    = 32'h0010_0093;
  localparam logic [31:0] W1    = 32'h0020_0113;
  localparam logic [31:0] W2    = 32'h0020_81B3;
  localparam logic [31:0] END_ADDR = 32'(4 * DEPTH);

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        misaligned;
`ifdef IMEM_LOAD_EN
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
`endif

  exp_t exp_q[$];
  event ev_sample;
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_memory #(
    .DEPTH_WORDS(DEPTH),
    .NOP_WORD   (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .instruction(instruction),
`ifdef IMEM_LOAD_EN
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
`endif
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Queue an expectation and ask the monitor to sample now.
  task automatic expect_rd(input string name, input logic [31:0] instr, input logic mis);
    exp_t e;
    e.name  = name;
    e.instr = instr;
    e.mis   = mis;
    exp_q.push_back(e);
    -> ev_sample;
    #1;
  endtask

  // Set pc, let the combinational path settle, then queue the expectation.
  task automatic read_at(input string name, input logic [31:0] addr,
                         input logic [31:0] instr, input logic mis);
    pc = addr;
    #1;
    expect_rd(name, instr, mis);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(ev_sample);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".instr"}, instruction, e.instr);
        check({e.name, ".mis"}, {31'b0, misaligned}, {31'b0, e.mis});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    pc    = 32'h0;
`ifdef IMEM_LOAD_EN
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;
`endif
    #2;
    // Reset state: forced NOP, misaligned still follows pc.
    read_at("rst_pc0", 32'd0, NOP, 1'b0);
    read_at("rst_pc5", 32'd5, NOP, 1'b1);

    // Release mid-cycle with no clock edge in between.
    pc = 32'd0;
    #1;
    rst_n = 1'b1;
    #1;
    expect_rd("release_pc0", W0, 1'b0);

    // Boot image walk.
    read_at("pc4",  32'd4,  W1,  1'b0);
    read_at("pc8",  32'd8,  W2,  1'b0);
    read_at("pc12", 32'd12, NOP, 1'b0);
    read_at("pc16", 32'd16, NOP, 1'b0);
    read_at("pc_last", END_ADDR - 32'd4, NOP, 1'b0);

    // Out of range.
    read_at("pc_end", END_ADDR, NOP, 1'b0);
    read_at("pc_top", 32'hFFFF_FFFC, NOP, 1'b0);
    read_at("pc_end_mis", END_ADDR + 32'd1, NOP, 1'b1);

    // Misaligned: data from truncated index.
    read_at("pc5", 32'd5, W1, 1'b1);
    read_at("pc6", 32'd6, W1, 1'b1);
    read_at("pc11", 32'd11, W2, 1'b1);

    // Reset pulse with no clock dependence.
    pc = 32'd0;
    #1;
    rst_n = 1'b0;
    #1;
    expect_rd("rst2_pc0", NOP, 1'b0);
    rst_n = 1'b1;
    #1;
    expect_rd("rst2_release", W0, 1'b0);

`ifdef IMEM_LOAD_EN
    // Same-address collision: old word before the edge, new after.
    @(negedge clk);
    pc        = 32'd12;
    load_en   = 1'b1;
    load_addr = 32'd12;
    load_data = 32'hDEAD_BEEF;
    #1;
    expect_rd("coll_before", NOP, 1'b0);
    @(posedge clk);
    #1;
    expect_rd("coll_after", 32'hDEAD_BEEF, 1'b0);

    // Back-to-back writes; last write to an address wins; byte offset ignored.
    @(negedge clk);
    load_addr = 32'd16;
    load_data = 32'h1111_1111;
    @(negedge clk);
    load_addr = 32'd22;
    load_data = 32'h2222_2222;
    @(negedge clk);
    load_addr = 32'd17;
    load_data = 32'h3333_3333;
    @(negedge clk);
    load_en = 1'b0;
    read_at("b2b_pc16", 32'd16, 32'h3333_3333, 1'b0);
    read_at("b2b_pc20", 32'd20, 32'h2222_2222, 1'b0);
    read_at("b2b_pc12", 32'd12, 32'hDEAD_BEEF, 1'b0);

    // Reset restores the boot image.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    read_at("rst3_pc12", 32'd12, NOP, 1'b0);
    read_at("rst3_pc16", 32'd16, NOP, 1'b0);

    // Out-of-range write dropped, no aliasing onto word 0.
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = END_ADDR;
    load_data = 32'h1234_5678;
    @(negedge clk);
    load_en = 1'b0;
    read_at("oor_pc0", 32'd0, W0, 1'b0);
    read_at("oor_pc_end", END_ADDR, NOP, 1'b0);

    // No write on an edge while in reset.
    @(negedge clk);
    rst_n     = 1'b0;
    load_en   = 1'b1;
    load_addr = 32'd4;
    load_data = 32'hCAFE_F00D;
    @(negedge clk);
    load_en = 1'b0;
    rst_n   = 1'b1;
    #1;
    read_at("rstwr_pc4", 32'd4, W1, 1'b0);
`endif

    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
